timebase_strobe_gen: RTL and testbench
======================================

Name: timebase_strobe_gen

Overview:
- Programmable timebase that drives the count-enable input of the capture-path counters.
- Divides clk_in by a runtime-loaded ratio and emits single-cycle enable strobes.
- Runs either a finite burst of strobes or continuously until aborted.
- Control logic starts it with a one-cycle start pulse; completion is reported through busy/done.

Parameters:
- DIV_WIDTH, 16, width of divider ratio; strobe period = div_val+1 clk_in cycles.
- BURST_WIDTH, 16, width of burst length and strobe counter.

Ports:
- clk_in  input  1  reference clock; all logic on its rising edge.
- rst  input  1  reset, asynchronous, active-high; clears all state.
- start  input  1  one-cycle request to begin a run; honoured only in IDLE.
- abort  input  1  terminate the current run; level-sampled.
- div_val  input  DIV_WIDTH  divider ratio minus one; latched on accepted start.
- burst_len  input  BURST_WIDTH  number of strobes per run; 0 = continuous; latched on accepted start.
- strobe_out  output  1  registered one-cycle enable strobe, connects to counter cnt_en.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse coincident with the final strobe of a finite burst.
- strobe_cnt  output  BURST_WIDTH  strobes issued in current/last run.

Behaviour:
- Reset (async, rst=1): state IDLE; strobe_out=0, busy=0, done=0, strobe_cnt=0; prescaler and latched div/burst registers = 0.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, RUN.
- IDLE:
  - start=1 and abort=0 at edge T0 → latch div_val into div_l and burst_len into burst_l; prescaler=0; strobe_cnt=0; busy=1; go RUN.
  - start=1 with abort=1 → ignored; stay IDLE.
- RUN, each edge:
  - abort=1 → go IDLE, busy=0, strobe_out=0, done=0; strobe_cnt holds; abort overrides a coincident terminal strobe.
  - else if prescaler==div_l → prescaler=0, strobe_out=1, strobe_cnt=strobe_cnt+1.
  - else → prescaler=prescaler+1, strobe_out=0.
- Strobe timing: first strobe is visible after edge T0+div_l+1, then every div_l+1 cycles.
  - div_l=0 → strobe_out high every cycle from T1 until the run ends.
- Termination (burst_l≠0), on the edge issuing strobe number burst_l:
  - strobe_out=1 and done=1 on that edge.
  - Same edge: busy=0, go IDLE.
  - Next edge: strobe_out=0, done=0.
  - strobe_cnt holds burst_l until the next accepted start.
- Continuous (burst_l=0): never self-terminates; strobe_cnt wraps modulo 2^BURST_WIDTH; done never asserts.
- start while in RUN: ignored, no restart.
- div_val/burst_len changes during RUN: ignored; only latched values are used.
- start on the same edge done is asserted: state is still RUN at that edge, so start is ignored. A new start is accepted on the following cycle.
- rst asserted mid-run: immediate return to reset values; any strobe in flight is dropped.
- Width rules:
  - prescaler is DIV_WIDTH bits and never exceeds div_l.
  - strobe_cnt comparison is an exact equality at BURST_WIDTH bits.

Test Plan:
- Reset values: assert rst mid-RUN with div_val=5 → all outputs 0 asynchronously, before the next clk_in edge; state IDLE after release.
- Finite burst, div_val=3, burst_len=4, start at T0 → strobes after T4, T8, T12, T16; done=1 and busy falls with the T16 strobe; strobe_cnt=4 held.
- div_val=0, burst_len=3 → strobe_out high for exactly 3 consecutive cycles T1–T3; done on T3; busy 1 for T0–T2.
- Continuous with small widths, BURST_WIDTH=4, div_val=0, burst_len=0 → strobe_cnt wraps 15→0; done stays 0. Then abort → IDLE next edge, strobe_out 0, strobe_cnt frozen.
- Ignored start: start pulse mid-RUN, plus div_val changed 3→7 mid-run → period stays 4 cycles; strobe_cnt not cleared.
- Abort vs terminal strobe: abort on the edge of the final strobe (div 2, burst 2) → no final strobe, done=0, strobe_cnt=1. Then start with abort=1 in IDLE → stays IDLE.

Source files
------------

// File: rtl/timebase_strobe_gen.sv
// -----------------------------------------------------------------------------
// timebase_strobe_gen
//
// Programmable timebase for the capture-path counters. It divides clk_in by a
// ratio that is loaded at run time and emits single-cycle enable strobes. A run
// produces either a finite burst of strobes or continues until it is aborted.
//
// Ports:
//   clk_in      reference clock; all logic runs on its rising edge
//   rst         asynchronous active-high reset; clears all state
//   start       one-cycle request to begin a run; only honoured in IDLE
//   abort       level-sampled request to terminate the current run
//   div_val     divider ratio minus one; latched when a start is accepted
//   burst_len   strobes per run, 0 = continuous; latched when a start is accepted
//   strobe_out  registered one-cycle enable strobe (drives counter cnt_en)
//   busy        high while a run is in progress
//   done        one-cycle pulse coincident with the final strobe of a burst
//   strobe_cnt  strobes issued in the current or most recent run
// -----------------------------------------------------------------------------
module timebase_strobe_gen #(
    parameter int DIV_WIDTH   = 16,
    parameter int BURST_WIDTH = 16
) (
    input  logic                   clk_in,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [DIV_WIDTH-1:0]   div_val,
    input  logic [BURST_WIDTH-1:0] burst_len,
    output logic                   strobe_out,
    output logic                   busy,
    output logic                   done,
    output logic [BURST_WIDTH-1:0] strobe_cnt
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                 state_r;
    state_t                 state_next_s;

    logic [DIV_WIDTH-1:0]   presc_r;
    logic [DIV_WIDTH-1:0]   presc_next_s;
    logic [DIV_WIDTH-1:0]   div_l_r;
    logic [DIV_WIDTH-1:0]   div_l_next_s;
    logic [BURST_WIDTH-1:0] burst_l_r;
    logic [BURST_WIDTH-1:0] burst_l_next_s;
    logic [BURST_WIDTH-1:0] cnt_r;
    logic [BURST_WIDTH-1:0] cnt_next_s;
    logic [BURST_WIDTH-1:0] cnt_inc_s;

    logic                   strobe_r;
    logic                   strobe_next_s;
    logic                   done_r;
    logic                   done_next_s;
    logic                   busy_r;
    logic                   busy_next_s;

    logic                   accept_s;
    logic                   tick_s;
    logic                   last_s;

    // Shared decode: start acceptance, prescaler wrap and terminal strobe.
    // abort has priority over a prescaler wrap, so a coincident terminal
    // strobe is suppressed.
    always_comb begin
        accept_s  = (state_r == ST_IDLE) && start && !abort;
        tick_s    = (state_r == ST_RUN) && !abort && (presc_r == div_l_r);
        cnt_inc_s = cnt_r + {{(BURST_WIDTH-1){1'b0}}, 1'b1};
        // burst_l == 0 selects continuous mode, which never terminates
        last_s    = tick_s && (burst_l_r != {BURST_WIDTH{1'b0}})
                           && (cnt_inc_s == burst_l_r);
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort || last_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Next values of the datapath and the registered outputs.
    always_comb begin
        presc_next_s   = presc_r;
        div_l_next_s   = div_l_r;
        burst_l_next_s = burst_l_r;
        cnt_next_s     = cnt_r;
        strobe_next_s  = 1'b0;
        done_next_s    = 1'b0;
        busy_next_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    div_l_next_s   = div_val;
                    burst_l_next_s = burst_len;
                    presc_next_s   = {DIV_WIDTH{1'b0}};
                    cnt_next_s     = {BURST_WIDTH{1'b0}};
                    busy_next_s    = 1'b1;
                end else begin
                    busy_next_s    = 1'b0;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    // strobe_cnt keeps the number of strobes already issued
                    presc_next_s = {DIV_WIDTH{1'b0}};
                    busy_next_s  = 1'b0;
                end else if (tick_s) begin
                    presc_next_s  = {DIV_WIDTH{1'b0}};
                    strobe_next_s = 1'b1;
                    cnt_next_s    = cnt_inc_s;
                    done_next_s   = last_s;
                    busy_next_s   = !last_s;
                end else begin
                    presc_next_s  = presc_r + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
                    busy_next_s   = 1'b1;
                end
            end
            default: begin
                presc_next_s = {DIV_WIDTH{1'b0}};
                busy_next_s  = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers with asynchronous clear.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            presc_r   <= {DIV_WIDTH{1'b0}};
            div_l_r   <= {DIV_WIDTH{1'b0}};
            burst_l_r <= {BURST_WIDTH{1'b0}};
            cnt_r     <= {BURST_WIDTH{1'b0}};
            strobe_r  <= 1'b0;
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            presc_r   <= presc_next_s;
            div_l_r   <= div_l_next_s;
            burst_l_r <= burst_l_next_s;
            cnt_r     <= cnt_next_s;
            strobe_r  <= strobe_next_s;
            done_r    <= done_next_s;
            busy_r    <= busy_next_s;
        end
    end

    assign strobe_out = strobe_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign strobe_cnt = cnt_r;

endmodule

// File: tb/tb_timebase_strobe_gen.sv
// -----------------------------------------------------------------------------
// tb_timebase_strobe_gen
//
// Self-checking bench for timebase_strobe_gen. A reference model describes a
// run as "cycles elapsed since the accepting edge": a strobe falls on every
// multiple of (div+1), and the strobe count is the quotient. Directed scenarios
// cover the documented corner cases, followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_timebase_strobe_gen;

    localparam int DW = 6;
    localparam int BW = 4;

    logic          clk_in;
    logic          rst;
    logic          start;
    logic          abort;
    logic [DW-1:0] div_val;
    logic [BW-1:0] burst_len;
    logic          strobe_out;
    logic          busy;
    logic          done;
    logic [BW-1:0] strobe_cnt;

    int checks_s;
    int failures_s;

    // reference model state
    bit            m_run;
    int            m_t;
    int            m_d;
    int            m_b;
    logic [BW-1:0] m_cnt;
    logic          m_strobe;
    logic          m_done;
    logic          m_busy;

    timebase_strobe_gen #(
        .DIV_WIDTH   (DW),
        .BURST_WIDTH (BW)
    ) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .div_val    (div_val),
        .burst_len  (burst_len),
        .strobe_out (strobe_out),
        .busy       (busy),
        .done       (done),
        .strobe_cnt (strobe_cnt)
    );

    // 10 time-unit reference clock
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_s++;
        if (obs !== exp) begin
            failures_s++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run    = 1'b0;
        m_t      = 0;
        m_d      = 0;
        m_b      = 0;
        m_cnt    = '0;
        m_strobe = 1'b0;
        m_done   = 1'b0;
        m_busy   = 1'b0;
    endtask

    // Advance the model by one clock edge using the currently applied inputs.
    task automatic model_edge();
        int n;
        int q;
        if (m_run) begin
            if (abort) begin
                m_run    = 1'b0;
                m_strobe = 1'b0;
                m_done   = 1'b0;
                m_busy   = 1'b0;
            end else begin
                m_t      = m_t + 1;
                n        = m_t;
                q        = n / (m_d + 1);
                m_strobe = ((n % (m_d + 1)) == 0);
                m_cnt    = q[BW-1:0];
                if (m_b != 0 && m_strobe && q == m_b) begin
                    m_run  = 1'b0;
                    m_done = 1'b1;
                    m_busy = 1'b0;
                end else begin
                    m_done = 1'b0;
                    m_busy = 1'b1;
                end
            end
        end else begin
            m_strobe = 1'b0;
            m_done   = 1'b0;
            if (start && !abort) begin
                m_run  = 1'b1;
                m_t    = 0;
                m_d    = int'(div_val);
                m_b    = int'(burst_len);
                m_cnt  = '0;
                m_busy = 1'b1;
            end else begin
                m_busy = 1'b0;
            end
        end
    endtask

    // One clock edge: update the model, then compare all outputs 1 unit later.
    task automatic tick();
        @(posedge clk_in);
        model_edge();
        #1;
        check_val("strobe_out", 32'(strobe_out), 32'(m_strobe));
        check_val("busy",       32'(busy),       32'(m_busy));
        check_val("done",       32'(done),       32'(m_done));
        check_val("strobe_cnt", 32'(strobe_cnt), 32'(m_cnt));
    endtask

    task automatic do_start(input int d, input int b);
        div_val   = DW'(d);
        burst_len = BW'(b);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    initial begin
        int n_str;
        int done_at;
        int last_k;
        int frozen;
        bit wrapped;
        logic [BW-1:0] prev_cnt;

        checks_s   = 0;
        failures_s = 0;
        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        div_val    = '0;
        burst_len  = '0;
        model_reset();

        // reset state
        #12;
        check_val("rst_strobe", 32'(strobe_out), 32'd0);
        check_val("rst_busy",   32'(busy),       32'd0);
        check_val("rst_done",   32'(done),       32'd0);
        check_val("rst_cnt",    32'(strobe_cnt), 32'd0);
        rst = 1'b0;
        tick();

        // finite burst: div 3, burst 4 -> strobes at T4, T8, T12, T16
        do_start(3, 4);
        n_str   = 0;
        done_at = -1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (strobe_out) begin
                n_str++;
                check_val("d34_strobe_phase", 32'(k % 4), 32'd0);
            end
            if (done) done_at = k;
        end
        check_val("d34_nstrobes", 32'(n_str),   32'd4);
        check_val("d34_done_at",  32'(done_at), 32'd16);
        for (int k = 0; k < 3; k++) tick();
        check_val("d34_cnt_hold", 32'(strobe_cnt), 32'd4);

        // div 0, burst 3 -> strobes T1..T3, done on T3
        do_start(0, 3);
        n_str = 0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (strobe_out) n_str++;
            if (k == 3) check_val("d03_done_t3", 32'(done), 32'd1);
        end
        check_val("d03_nstrobes", 32'(n_str), 32'd3);

        // continuous: div 0, burst 0 -> strobe_cnt wraps 15 -> 0
        do_start(0, 0);
        wrapped  = 1'b0;
        prev_cnt = strobe_cnt;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (prev_cnt == 4'd15 && strobe_cnt == 4'd0) wrapped = 1'b1;
            prev_cnt = strobe_cnt;
        end
        check_val("cont_wrap_seen", 32'(wrapped), 32'd1);
        abort = 1'b1;
        tick();
        abort  = 1'b0;
        frozen = int'(strobe_cnt);
        check_val("cont_abort_busy", 32'(busy), 32'd0);
        for (int k = 0; k < 4; k++) tick();
        check_val("cont_cnt_frozen", 32'(strobe_cnt), 32'(frozen));

        // start and div_val change mid-run are ignored; period stays 4
        do_start(3, 0);
        last_k = -1;
        for (int k = 1; k <= 24; k++) begin
            if (k == 6) begin
                div_val = 6'd7;
                start   = 1'b1;
            end else begin
                start   = 1'b0;
            end
            tick();
            if (strobe_out) begin
                if (last_k >= 0) check_val("ign_period", 32'(k - last_k), 32'd4);
                last_k = k;
            end
        end
        check_val("ign_cnt_kept", 32'(strobe_cnt), 32'd6);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // abort on the final-strobe edge: div 2, burst 2, final strobe at T6
        do_start(2, 2);
        for (int k = 1; k <= 5; k++) tick();
        abort = 1'b1;
        tick();
        check_val("abt_no_strobe", 32'(strobe_out), 32'd0);
        check_val("abt_no_done",   32'(done),       32'd0);
        check_val("abt_cnt",       32'(strobe_cnt), 32'd1);
        // start together with abort in IDLE is ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check_val("abt_start_ign", 32'(busy), 32'd0);
        tick();

        // asynchronous reset mid-run, while a strobe is visible
        do_start(5, 0);
        for (int k = 1; k <= 6; k++) tick();
        check_val("mid_strobe_pre", 32'(strobe_out), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_val("mid_rst_strobe", 32'(strobe_out), 32'd0);
        check_val("mid_rst_busy",   32'(busy),       32'd0);
        check_val("mid_rst_done",   32'(done),       32'd0);
        check_val("mid_rst_cnt",    32'(strobe_cnt), 32'd0);
        model_reset();
        #1;
        rst = 1'b0;
        tick();
        tick();

        // randomized phase
        for (int k = 0; k < 3000; k++) begin
            start     = ($urandom_range(0, 7) == 0);
            abort     = ($urandom_range(0, 39) == 0);
            div_val   = DW'($urandom_range(0, 5));
            burst_len = ($urandom_range(0, 3) == 0) ? '0 : BW'($urandom_range(1, 15));
            tick();
        end
        start = 1'b0;
        abort = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks_s, failures_s);
        $finish;
    end

endmodule
